// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: PC input, flush, instruction-memory request/response
// and the valid/ready path toward decode.
interface if_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic [XLEN-1:0] pc_in;
  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_gnt;
  logic            im_rvalid;
  logic [XLEN-1:0] im_rdata;
  logic            im_stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            id_ready;

  modport master (
    input  pc_in, flush, im_gnt, im_rvalid, im_rdata, id_ready,
    output im_req, im_addr, im_stall, id_valid, id_pc, id_instr
  );

  modport slave (
    output pc_in, flush, im_gnt, im_rvalid, im_rdata, id_ready,
    input  im_req, im_addr, im_stall, id_valid, id_pc, id_instr
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: one outstanding memory request at a time, returned
// instructions buffered with their PC in a small FIFO toward decode.
module if_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic               clk,
  input  logic               reset,
  if_fetch_queue_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e          r_state;
  logic            r_drop;
  logic [XLEN-1:0] r_addr_q;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];

  logic w_space;
  logic w_req;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_valid;

  // Nothing is outstanding in REQ, so the count alone decides whether a
  // returning instruction is guaranteed a free slot.
  assign w_space = (r_count < CW'(DEPTH));
  assign w_req   = reset && (r_state == S_REQ) && !bus.flush && w_space;
  assign w_issue = w_req && bus.im_gnt;
  assign w_valid = (r_count != '0);
  assign w_push  = (r_state == S_WAIT) && bus.im_rvalid && !r_drop && !bus.flush;
  assign w_pop   = w_valid && bus.id_ready && !bus.flush;

  assign bus.im_req   = w_req;
  assign bus.im_addr  = w_req ? bus.pc_in : r_addr_q;
  assign bus.im_stall = !w_issue;
  assign bus.id_valid = w_valid;
  // Head data reads as zero while empty so storage contents never leak out.
  assign bus.id_pc    = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign bus.id_instr = w_valid ? r_instr_mem[r_rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_REQ;
      r_drop   <= 1'b0;
      r_addr_q <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_issue) begin
            r_addr_q <= bus.pc_in;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.im_rvalid) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end else if (bus.flush) begin
            r_drop  <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // written, and leaving it unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_addr_q;
      r_instr_mem[r_wr_ptr] <= bus.im_rdata;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: each cycle's inputs are applied on the
// falling edge and the expected outputs are hand-derived.
module tb_if_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  if_fetch_queue_if #(.XLEN(32)) bus ();

  if_fetch_queue #(.DEPTH(2), .XLEN(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] pc, input logic fl, input logic gnt,
                     input logic rv, input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    bus.pc_in     = pc;
    bus.flush     = fl;
    bus.im_gnt    = gnt;
    bus.im_rvalid = rv;
    bus.im_rdata  = rd;
    bus.id_ready  = rdy;
    #1;
  endtask

  task automatic req(input string tag, input logic r, input logic [31:0] a, input logic st);
    check({tag, ".im_req"}, {31'b0, bus.im_req}, {31'b0, r});
    if (r) check({tag, ".im_addr"}, bus.im_addr, a);
    check({tag, ".im_stall"}, {31'b0, bus.im_stall}, {31'b0, st});
  endtask

  task automatic idq(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, ".id_valid"}, {31'b0, bus.id_valid}, {31'b0, v});
    check({tag, ".id_pc"}, bus.id_pc, pc);
    check({tag, ".id_instr"}, bus.id_instr, ins);
  endtask

  initial begin
    bus.pc_in = 32'h55; bus.flush = 0; bus.im_gnt = 1; bus.im_rvalid = 0;
    bus.im_rdata = 0; bus.id_ready = 0;
    #2;
    req("rst", 1'b0, 32'h0, 1'b1);
    check("rst.im_addr", bus.im_addr, 32'h0);
    idq("rst", 1'b0, 32'h0, 32'h0);

    // Basic stream
    cyc(32'h0, 0, 1, 0, 0, 1); rst_n = 1'b1; #1;
    req("s0", 1, 32'h0, 0);
    cyc(32'h4, 0, 1, 1, 32'h13, 1);   req("s0w", 0, 0, 1); idq("s0w", 0, 0, 0);
    cyc(32'h4, 0, 1, 0, 0, 1);        idq("s1", 1, 32'h0, 32'h13); req("s1", 1, 32'h4, 0);
    cyc(32'h8, 0, 1, 1, 32'h93, 1);   idq("s1w", 0, 0, 0); req("s1w", 0, 0, 1);
    cyc(32'h8, 0, 1, 0, 0, 1);        idq("s2", 1, 32'h4, 32'h93); req("s2", 1, 32'h8, 0);
    cyc(32'hC, 0, 0, 1, 32'h113, 1);  idq("s2w", 0, 0, 0);
    cyc(32'h10, 0, 0, 0, 0, 1);       idq("s3", 1, 32'h8, 32'h113); req("s3", 1, 32'h10, 1);

    // Backpressure: fill both entries with decode stalled
    cyc(32'h10, 0, 1, 0, 0, 0);       idq("b0", 0, 0, 0); req("b0", 1, 32'h10, 0);
    cyc(32'h14, 0, 1, 1, 32'hA0, 0);
    cyc(32'h14, 0, 1, 0, 0, 0);       idq("b1", 1, 32'h10, 32'hA0); req("b1", 1, 32'h14, 0);
    cyc(32'h18, 0, 1, 1, 32'hA4, 0);
    cyc(32'h18, 0, 1, 0, 0, 0);       idq("bfull0", 1, 32'h10, 32'hA0); req("bfull0", 0, 0, 1);
    cyc(32'h18, 0, 1, 0, 0, 0);       idq("bfull1", 1, 32'h10, 32'hA0); req("bfull1", 0, 0, 1);
    cyc(32'h18, 0, 1, 0, 0, 1);       idq("bpop0", 1, 32'h10, 32'hA0); req("bpop0", 0, 0, 1);
    cyc(32'h18, 0, 1, 0, 0, 1);       idq("bpop1", 1, 32'h14, 32'hA4); req("bpop1", 1, 32'h18, 0);
    cyc(32'h1C, 0, 0, 1, 32'hA8, 0);  idq("bempty", 0, 0, 0);

    // Grant stall for three cycles, then grant
    for (int i = 0; i < 3; i++) begin
      cyc(32'h1C, 0, 0, 0, 0, 0);
      req($sformatf("g%0d", i), 1, 32'h1C, 1);
      idq($sformatf("g%0d", i), 1, 32'h18, 32'hA8);
    end
    cyc(32'h1C, 0, 1, 0, 0, 0);       req("g3", 1, 32'h1C, 0);

    // Flush coincident with rvalid and pop while one entry is queued
    cyc(32'h20, 1, 1, 1, 32'hBAD, 1); idq("fr", 1, 32'h18, 32'hA8); req("fr", 0, 0, 1);
    cyc(32'h200, 0, 1, 0, 0, 0);      idq("fr1", 0, 0, 0); req("fr1", 1, 32'h200, 0);
    cyc(32'h204, 0, 1, 1, 32'h77, 0);
    cyc(32'h204, 0, 1, 0, 0, 0);      idq("fr2", 1, 32'h200, 32'h77); req("fr2", 1, 32'h204, 0);

    // Flush in WAIT: late response must be discarded
    cyc(32'h100, 1, 1, 0, 0, 0);      req("fw", 0, 0, 1); idq("fw", 1, 32'h200, 32'h77);
    cyc(32'h100, 0, 1, 0, 0, 0);      idq("fw1", 0, 0, 0); req("fw1", 0, 0, 1);
    cyc(32'h100, 0, 1, 1, 32'hDEAD, 1); req("fw2", 0, 0, 1);
    cyc(32'h100, 0, 1, 0, 0, 1);      idq("fw3", 0, 0, 0); req("fw3", 1, 32'h100, 0);
    cyc(32'h104, 0, 1, 1, 32'h55, 0);

    // Flush in REQ suppresses the request
    cyc(32'h104, 1, 1, 0, 0, 0);      idq("fq", 1, 32'h100, 32'h55); req("fq", 0, 0, 1);
    cyc(32'h300, 0, 1, 0, 0, 0);      idq("fq1", 0, 0, 0); req("fq1", 1, 32'h300, 0);
    cyc(32'h304, 0, 1, 1, 32'h66, 0);
    cyc(32'h304, 0, 1, 0, 0, 0);      idq("ar0", 1, 32'h300, 32'h66);

    // Async reset mid-WAIT, then a stale response after release
    cyc(32'h304, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    idq("ar", 0, 0, 0); req("ar", 0, 0, 1);
    check("ar.im_addr", bus.im_addr, 32'h0);
    cyc(32'h400, 0, 0, 1, 32'h99, 0); rst_n = 1'b1; #1;
    req("ar1", 1, 32'h400, 1);
    cyc(32'h400, 0, 0, 0, 0, 0);      idq("ar2", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch stage placed directly downstream of the program counter and upstream of decode. It takes the current PC value and issues one instruction-memory request at a time. Each returned instruction is buffered with its PC in a small FIFO and presented to ID under a valid/ready handshake. It drives the im_stall back to the PC so the PC advances only when its fetch has been accepted. It also discards in-flight and queued instructions on a flush (branch taken, CSR interrupt or return).

Parameters:
DEPTH, 2, number of FIFO entries (power of two, at least 2)
XLEN, 32, address and instruction width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
pc_in  in  XLEN  current PC (PC register output)
flush  in  1  redirect; drop all queued and in-flight fetches
im_req  out  1  instruction-memory request valid
im_addr  out  XLEN  request address
im_gnt  in  1  memory accepts request this cycle
im_rvalid  in  1  read data valid
im_rdata  in  XLEN  read data
im_stall  out  1  to PC: high when PC must hold
id_valid  out  1  head entry valid toward decode
id_pc  out  XLEN  PC of head entry
id_instr  out  XLEN  instruction of head entry
id_ready  in  1  decode consumes head this cycle

Behaviour:
- Reset (reset low, async): state=REQ, FIFO empty (count=0, rd/wr ptr=0), drop=0, addr_q=0; outputs im_req=0, im_addr=0, id_valid=0, id_pc=0, id_instr=0, im_stall=1.
- States: REQ (may issue), WAIT (one request outstanding). Exactly 0 or 1 request outstanding.
- REQ: im_req = ~flush & (count < DEPTH); im_addr = pc_in (combinational). On im_req & im_gnt, latch addr_q=pc_in, go to WAIT.
- WAIT: im_req=0. On im_rvalid: if drop=0, push {addr_q, im_rdata}; clear drop; go to REQ. The next request is issued no earlier than the following cycle.
- im_stall = ~(im_req & im_gnt). The PC advances only in the grant cycle.
- Space rule: a request is issued only when count + outstanding < DEPTH. A push therefore never hits a full FIFO; no overflow path exists.
- ID side: id_valid = (count != 0); id_pc/id_instr come from the head entry (registered storage, no rdata bypass). An instruction appears on id_* the cycle after im_rvalid. Pop on id_valid & id_ready. Simultaneous push and pop leaves count unchanged and both take effect.
- id_ready while id_valid=0 is ignored. Head data is held stable while id_valid & ~id_ready.
- flush (synchronous, highest priority):
  - FIFO cleared (count=0, ptrs=0) and id_valid=0 the next cycle.
  - Any pop or push in the flush cycle is cancelled.
  - In REQ: im_req forced 0 that cycle.
  - In WAIT with im_rvalid not in the same cycle: drop=1, stay WAIT; the stale response is discarded on arrival, then go to REQ.
  - In WAIT with im_rvalid in the same cycle: data discarded, go to REQ, drop stays 0.
  - flush while drop=1: no additional effect.
- count width: clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- Reset asserted mid-transaction: everything returns to reset values immediately. A late im_rvalid after reset release while in REQ is ignored (no push in REQ).

Test Plan:
- Basic stream:
  - Stimulus: pc_in=0x0,0x4,0x8; im_gnt=1 always; im_rvalid one cycle after grant with rdata=0x13,0x93,0x113; id_ready=1.
  - Required: id_valid pulses with (0x0,0x13),(0x4,0x93),(0x8,0x113) in order. im_stall=0 only in grant cycles.
- Backpressure:
  - Stimulus: id_ready=0 with DEPTH=2.
  - Required: after two returns count=2, im_req stays 0, im_stall=1, head holds (0x0,0x13). Raise id_ready: one pop per cycle, then request resumes.
- Grant stall:
  - Stimulus: im_gnt=0 for 3 cycles.
  - Required: im_req=1, im_addr=pc_in, im_stall=1 for those cycles; grant on cycle 4 gives im_stall=0 for exactly 1 cycle.
- Flush in WAIT:
  - Stimulus: grant at 0x8, flush before rvalid, rdata=0xDEAD arrives 2 cycles later.
  - Required: 0xDEAD never appears on id_*, FIFO empty, next request uses the new pc_in=0x100.
- Flush with same-cycle rvalid, push and pop:
  - Stimulus: count=1, flush coincident with im_rvalid and id_ready.
  - Required: next cycle count=0, id_valid=0, state=REQ, drop=0.
- Async reset mid-WAIT:
  - Stimulus: reset low asynchronously.
  - Required: outputs at reset values before the next clk edge. A post-reset rvalid produces no push.
